// File: rtl/mips_intr_pkg.sv
// Shared types and defaults for the interrupt controller.
package mips_intr_pkg;

  localparam int          ID_W           = 5;
  localparam int          N_SRC_DEF      = 8;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module intr_prio_enc
  import mips_intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable interrupt controller driving the MCU intr/ack handshake
// and exporting the serviced id and its handler vector.
module interrupt_controller
  import mips_intr_pkg::*;
#(
  parameter int          N_SRC      = N_SRC_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  output logic             intr,
  input  logic             intr_ack,
  input  logic             isr_done,
  output logic [ID_W-1:0]  active_id,
  output logic [31:0]      vec_addr,
  output logic             busy,
  output logic [N_SRC-1:0] pend_out
);

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  irq_prev_q, pending_q, pending_d, mask_q;
  logic [N_SRC-1:0]  rise, clr;
  logic [ID_W-1:0]   active_id_q, win_id;
  logic [31:0]       vec_addr_q, vec_d;
  logic              win_vld, ack_fire, latch;

  intr_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req_i   (pending_q & mask_q),
    .valid_o (win_vld),
    .id_o    (win_id)
  );

  assign rise      = irq_in & ~irq_prev_q;
  assign ack_fire  = (state_q == REQ) && intr_ack;
  assign latch     = (state_q == IDLE) && win_vld;
  // A new edge on the acked source in the same cycle keeps its bit set.
  assign clr       = ack_fire ? (N_SRC'(1) << active_id_q) : '0;
  assign pending_d = (pending_q & ~clr) | rise;
  assign vec_d     = VEC_BASE + 32'(VEC_STRIDE) * 32'(win_id);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      active_id_q <= '0;
      vec_addr_q  <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (mask_wr) mask_q <= mask_din;
      if (latch) begin
        active_id_q <= win_id;
        vec_addr_q  <= vec_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld)  state_d = REQ;
      REQ:     if (intr_ack) state_d = SERVICE;
      SERVICE: if (isr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    intr = (state_q == REQ);
    busy = (state_q != IDLE);
  end

  assign active_id = active_id_q;
  assign vec_addr  = vec_addr_q;
  assign pend_out  = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic        sys_clk;
  logic        reset;
  logic [7:0]  irq_in;
  logic        mask_wr;
  logic [7:0]  mask_din;
  logic        intr;
  logic        intr_ack;
  logic        isr_done;
  logic [4:0]  active_id;
  logic [31:0] vec_addr;
  logic        busy;
  logic [7:0]  pend_out;

  int checks;
  int failures;

  interrupt_controller dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .intr      (intr),
    .intr_ack  (intr_ack),
    .isr_done  (isr_done),
    .active_id (active_id),
    .vec_addr  (vec_addr),
    .busy      (busy),
    .pend_out  (pend_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wr = 1'b1; mask_din = m;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic pulse_ack();
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
  endtask

  task automatic pulse_done();
    isr_done = 1'b1; tick(); isr_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_din = '0;
    intr_ack = 1'b0; isr_done = 1'b0;
    tick(); tick();
    checks++;
    if ({intr, busy, active_id, vec_addr, pend_out} !== {1'b0, 1'b0, 5'd0, 32'h100, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got intr=%0b busy=%0b id=%0d vec=%h pend=%h, want 0 0 0 00000100 00",
               intr, busy, active_id, vec_addr, pend_out);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    write_mask(8'hFF);
    irq_in = 8'h08; tick();
    checks++;
    if ({intr, pend_out} !== {1'b0, 8'h08}) begin
      failures++;
      $display("FAIL single_pending got intr=%0b pend=%h, want 0 08", intr, pend_out);
    end
    tick();
    checks++;
    if ({intr, busy, active_id, vec_addr} !== {1'b1, 1'b1, 5'd3, 32'h10C}) begin
      failures++;
      $display("FAIL single_req got intr=%0b busy=%0b id=%0d vec=%h, want 1 1 3 0000010c",
               intr, busy, active_id, vec_addr);
    end
    pulse_ack();
    checks++;
    if ({intr, busy, pend_out} !== {1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL single_ack got intr=%0b busy=%0b pend=%h, want 0 1 00", intr, busy, pend_out);
    end
    pulse_done();
    checks++;
    if ({intr, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_done got intr=%0b busy=%0b, want 0 0", intr, busy);
    end
    irq_in = '0; tick();
  endtask

  task automatic test_priority();
    irq_in = 8'h24; tick();
    irq_in = 8'h00; tick();
    checks++;
    if ({intr, active_id, vec_addr} !== {1'b1, 5'd2, 32'h108}) begin
      failures++;
      $display("FAIL prio_first got intr=%0b id=%0d vec=%h, want 1 2 00000108", intr, active_id, vec_addr);
    end
    pulse_ack();
    checks++;
    if (pend_out !== 8'h20) begin
      failures++;
      $display("FAIL prio_pend_after_ack got %h, want 20", pend_out);
    end
    pulse_done();
    checks++;
    if ({intr, busy} !== 2'b00) begin
      failures++;
      $display("FAIL prio_idle_gap got intr=%0b busy=%0b, want 0 0", intr, busy);
    end
    tick();
    checks++;
    if ({intr, active_id, vec_addr} !== {1'b1, 5'd5, 32'h114}) begin
      failures++;
      $display("FAIL prio_second got intr=%0b id=%0d vec=%h, want 1 5 00000114", intr, active_id, vec_addr);
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_mask();
    write_mask(8'h00);
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick();
    checks++;
    if ({intr, pend_out} !== {1'b0, 8'h02}) begin
      failures++;
      $display("FAIL mask_hold got intr=%0b pend=%h, want 0 02", intr, pend_out);
    end
    write_mask(8'h02);
    checks++;
    if (intr !== 1'b0) begin
      failures++;
      $display("FAIL mask_early got intr=%0b, want 0", intr);
    end
    tick();
    checks++;
    if ({intr, active_id} !== {1'b1, 5'd1}) begin
      failures++;
      $display("FAIL mask_release got intr=%0b id=%0d, want 1 1", intr, active_id);
    end
    pulse_ack();
    pulse_done();
    write_mask(8'hFF);
  endtask

  task automatic test_set_beats_clear();
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h08; intr_ack = 1'b1; tick();
    irq_in = 8'h00; intr_ack = 1'b0;
    checks++;
    if ({intr, busy, pend_out} !== {1'b0, 1'b1, 8'h08}) begin
      failures++;
      $display("FAIL sbc_ack got intr=%0b busy=%0b pend=%h, want 0 1 08", intr, busy, pend_out);
    end
    pulse_done();
    tick();
    checks++;
    if ({intr, active_id} !== {1'b1, 5'd3}) begin
      failures++;
      $display("FAIL sbc_rereq got intr=%0b id=%0d, want 1 3", intr, active_id);
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_stray();
    pulse_ack();
    checks++;
    if ({intr, busy, pend_out} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL stray_ack_idle got intr=%0b busy=%0b pend=%h, want 0 0 00", intr, busy, pend_out);
    end
    irq_in = 8'h10; tick();
    irq_in = 8'h00; tick();
    pulse_done();
    checks++;
    if ({intr, busy, active_id} !== {1'b1, 1'b1, 5'd4}) begin
      failures++;
      $display("FAIL stray_done_req got intr=%0b busy=%0b id=%0d, want 1 1 4", intr, busy, active_id);
    end
    pulse_ack();
    checks++;
    if ({intr, busy} !== 2'b01) begin
      failures++;
      $display("FAIL stray_ack_after got intr=%0b busy=%0b, want 0 1", intr, busy);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h41; tick();
    irq_in = 8'h00; tick();
    checks++;
    if ({intr, active_id, pend_out} !== {1'b1, 5'd0, 8'h41}) begin
      failures++;
      $display("FAIL rst_req_setup got intr=%0b id=%0d pend=%h, want 1 0 41", intr, active_id, pend_out);
    end
    reset = 1'b0; #2;
    checks++;
    if ({intr, busy, pend_out, vec_addr} !== {1'b0, 1'b0, 8'h00, 32'h100}) begin
      failures++;
      $display("FAIL rst_in_req got intr=%0b busy=%0b pend=%h vec=%h, want 0 0 00 00000100",
               intr, busy, pend_out, vec_addr);
    end
    tick(); reset = 1'b1;
    write_mask(8'hFF); tick(); tick();
    checks++;
    if ({intr, busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_req_quiet got intr=%0b busy=%0b, want 0 0", intr, busy);
    end
    irq_in = 8'h04; tick();
    irq_in = 8'h00; tick();
    pulse_ack();
    checks++;
    if ({intr, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rst_svc_setup got intr=%0b busy=%0b, want 0 1", intr, busy);
    end
    reset = 1'b0; #2;
    checks++;
    if ({intr, busy, pend_out} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL rst_in_svc got intr=%0b busy=%0b pend=%h, want 0 0 00", intr, busy, pend_out);
    end
    tick(); reset = 1'b1;
    write_mask(8'hFF); tick(); tick();
    checks++;
    if ({intr, busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_svc_quiet got intr=%0b busy=%0b, want 0 0", intr, busy);
    end
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick();
    checks++;
    if ({intr, active_id, vec_addr} !== {1'b1, 5'd1, 32'h104}) begin
      failures++;
      $display("FAIL rst_new_edge got intr=%0b id=%0d vec=%h, want 1 1 00000104", intr, active_id, vec_addr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_set_beats_clear();
    test_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
